// File: rtl/ether_rx_ring.sv
// rtl/ether_rx_ring.sv - MII nibble receiver into a ring of frame slots with a host command port
module ether_rx_ring #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int SLOTS     = 4,
    parameter int CHECK_FCS = 1
) (
    input  logic                   erx_clk,
    input  logic                   erx_rst_n,
    input  logic [3:0]             erx_rxd,
    input  logic                   erx_dv,
    input  logic                   erx_err,
    input  logic                   erx_cs,
    input  logic [3:0]             erx_cmd,
    output logic                   erx_ready,
    output logic [DATA_W-1:0]      erx_data,
    output logic [$clog2(SLOTS):0] erx_frames,
    output logic [7:0]             erx_drops
);
    localparam int SW    = $clog2(SLOTS);
    localparam int NPW   = DATA_W / 4;
    localparam int NI_W  = $clog2(NPW);
    localparam int LEN_W = DATA_W - 4;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRE    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_DROP   = 3'd4;

    localparam logic [3:0] CMD_STAT = 4'd1;
    localparam logic [3:0] CMD_DATA = 4'd2;
    localparam logic [3:0] CMD_REL  = 4'd3;

    logic [2:0]        state;
    logic              dv_q;
    logic [SW-1:0]     wr_slot, rd_slot;
    logic [ADDR_W:0]   rd_ptr, word_idx;
    logic [NI_W-1:0]   nib_idx;
    logic [DATA_W-1:0] word_buf;
    logic [LEN_W-1:0]  byte_cnt;
    logic [31:0]       crc, crc_byte;
    logic              f_err, f_ovf;
    logic              p1;
    logic [3:0]        p1_cmd;

    logic [DATA_W-1:0] mem [SLOTS*DEPTH];
    logic [LEN_W-1:0]  d_len [SLOTS];
    logic [ADDR_W:0]   d_nw  [SLOTS];
    logic              d_fcs [SLOTS];
    logic              d_err [SLOTS];
    logic              d_ovf [SLOTS];
    logic              d_runt[SLOTS];

    function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++)
            r[i] = v[31-i];
        return r;
    endfunction

    logic [31:0]          crc_next;
    logic [DATA_W-1:0]    packed_word, tail_word, wr_word, rsp;
    logic                 word_full, has_tail, full, fcs_ok, wr_en;
    logic                 have, accept, commit, rel_exec;
    logic [SW+ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]      head_nw;

    assign crc_next    = crc_nibble(crc, erx_rxd);
    assign packed_word = word_buf | (DATA_W'(erx_rxd) << {nib_idx, 2'b00});
    assign word_full   = nib_idx == NI_W'(NPW - 1);
    // A lone trailing nibble is never a whole byte, so it does not count as a tail word
    assign has_tail    = (nib_idx >> 1) != '0;
    assign tail_word   = nib_idx[0] ? (word_buf & ~(DATA_W'(4'hF) << {nib_idx - 1'b1, 2'b00}))
                                    : word_buf;
    assign full        = erx_frames == (SW+1)'(SLOTS);
    assign fcs_ok      = (CHECK_FCS == 0) || (bit_rev(crc_byte) == 32'hC704DD7B);
    assign wr_addr     = {wr_slot, word_idx[ADDR_W-1:0]};
    assign commit      = state == S_COMMIT;

    assign have     = erx_frames != '0;
    assign accept   = erx_cs && !p1 && (erx_cmd == CMD_STAT || erx_cmd == CMD_DATA || erx_cmd == CMD_REL);
    assign rel_exec = p1 && have && p1_cmd == CMD_REL;
    assign head_nw  = d_nw[rd_slot];

    always_comb begin
        wr_en   = 1'b0;
        wr_word = packed_word;
        if (state == S_DATA && erx_dv && word_full && !word_idx[ADDR_W]) begin
            wr_en = 1'b1;
        end else if (commit && has_tail && !word_idx[ADDR_W]) begin
            wr_en   = 1'b1;
            wr_word = tail_word;
        end
    end

    always_comb begin
        rsp = '0;
        if (p1 && have) begin
            if (p1_cmd == CMD_STAT)
                rsp = {d_ovf[rd_slot], d_runt[rd_slot], d_err[rd_slot], d_fcs[rd_slot], d_len[rd_slot]};
            else if (p1_cmd == CMD_DATA && rd_ptr < head_nw)
                rsp = mem[{rd_slot, rd_ptr[ADDR_W-1:0]}];
        end
    end

    always_ff @(posedge erx_clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_word;
        if (commit) begin
            d_len[wr_slot]  <= byte_cnt;
            d_fcs[wr_slot]  <= fcs_ok;
            d_err[wr_slot]  <= f_err;
            d_ovf[wr_slot]  <= f_ovf | (has_tail & word_idx[ADDR_W]);
            d_runt[wr_slot] <= byte_cnt < LEN_W'(64);
            d_nw[wr_slot]   <= word_idx + (ADDR_W+1)'(has_tail & !word_idx[ADDR_W]);
        end
    end

    always_ff @(posedge erx_clk or negedge erx_rst_n) begin
        if (!erx_rst_n) begin
            state      <= S_IDLE;
            dv_q       <= 1'b1;
            wr_slot    <= '0;
            rd_slot    <= '0;
            rd_ptr     <= '0;
            word_idx   <= '0;
            nib_idx    <= '0;
            word_buf   <= '0;
            byte_cnt   <= '0;
            crc        <= '1;
            crc_byte   <= '1;
            f_err      <= 1'b0;
            f_ovf      <= 1'b0;
            p1         <= 1'b0;
            p1_cmd     <= '0;
            erx_ready  <= 1'b0;
            erx_data   <= '0;
            erx_frames <= '0;
            erx_drops  <= '0;
        end else begin
            // dv_q resets high so a frame already under way at reset release is skipped
            dv_q <= erx_dv;
            case (state)
                S_IDLE: if (erx_dv && !dv_q) state <= S_PRE;
                S_PRE: begin
                    if (!erx_dv) begin
                        state <= S_IDLE;
                    end else if (full) begin
                        state <= S_DROP;
                    end else if (erx_rxd == 4'hD) begin
                        state    <= S_DATA;
                        nib_idx  <= '0;
                        word_idx <= '0;
                        word_buf <= '0;
                        byte_cnt <= '0;
                        crc      <= '1;
                        crc_byte <= '1;
                        f_err    <= 1'b0;
                        f_ovf    <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (erx_err) f_err <= 1'b1;
                    if (!erx_dv) begin
                        state <= S_COMMIT;
                    end else begin
                        crc <= crc_next;
                        if (nib_idx[0]) begin
                            crc_byte <= crc_next;
                            byte_cnt <= byte_cnt + LEN_W'(1);
                        end
                        if (word_full) begin
                            nib_idx  <= '0;
                            word_buf <= '0;
                            if (word_idx[ADDR_W]) f_ovf <= 1'b1;
                            else                  word_idx <= word_idx + (ADDR_W+1)'(1);
                        end else begin
                            nib_idx  <= nib_idx + NI_W'(1);
                            word_buf <= packed_word;
                        end
                    end
                end
                S_COMMIT: begin
                    state   <= S_IDLE;
                    wr_slot <= wr_slot + SW'(1);
                end
                S_DROP: begin
                    if (!erx_dv) begin
                        state <= S_IDLE;
                        if (erx_drops != 8'hFF) erx_drops <= erx_drops + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            p1 <= accept;
            if (accept) p1_cmd <= erx_cmd;
            erx_ready <= p1;
            if (p1) erx_data <= rsp;
            if (p1 && have) begin
                case (p1_cmd)
                    CMD_STAT: rd_ptr <= '0;
                    CMD_DATA: if (rd_ptr < head_nw) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
                    CMD_REL: begin
                        rd_slot <= rd_slot + SW'(1);
                        rd_ptr  <= '0;
                    end
                    default: ;
                endcase
            end

            case ({commit, rel_exec})
                2'b10:   erx_frames <= erx_frames + (SW+1)'(1);
                2'b01:   erx_frames <= erx_frames - (SW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ether_rx_ring.sv
// tb/tb_ether_rx_ring.sv - randomized frame/command bench against a FIFO-of-frames reference model
module tb_ether_rx_ring;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int SLOTS  = 4;
    localparam int CAP    = (1 << ADDR_W) * DATA_W / 8;

    logic              erx_clk = 1'b0;
    logic              erx_rst_n = 1'b0;
    logic [3:0]        erx_rxd = 4'd0;
    logic              erx_dv = 1'b0;
    logic              erx_err = 1'b0;
    logic              erx_cs = 1'b0;
    logic [3:0]        erx_cmd = 4'd0;
    logic              erx_ready;
    logic [DATA_W-1:0] erx_data;
    logic [2:0]        erx_frames;
    logic [7:0]        erx_drops;

    int checks = 0;
    int errors = 0;

    logic [7:0] fb[$];
    logic [7:0] m_data[SLOTS][$];
    bit         m_err[SLOTS];
    int         m_head = 0;
    int         m_cnt = 0;
    int         m_drops = 0;

    ether_rx_ring #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SLOTS(SLOTS), .CHECK_FCS(1)) dut (
        .erx_clk(erx_clk), .erx_rst_n(erx_rst_n), .erx_rxd(erx_rxd), .erx_dv(erx_dv),
        .erx_err(erx_err), .erx_cs(erx_cs), .erx_cmd(erx_cmd), .erx_ready(erx_ready),
        .erx_data(erx_data), .erx_frames(erx_frames), .erx_drops(erx_drops)
    );

    always #5 erx_clk = ~erx_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge erx_clk);
        #1;
    endtask

    function automatic logic [31:0] crc32_q(input logic [7:0] q[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, q[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Ethernet frame: random payload followed by its FCS, least significant byte first
    task automatic make_frame(input int n);
        logic [31:0] c;
        fb.delete();
        for (int i = 0; i < n - 4; i++) fb.push_back(8'($urandom));
        c = crc32_q(fb, n - 4);
        for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
    endtask

    function automatic bit model_fcs(input int s);
        int n;
        logic [31:0] c;
        n = m_data[s].size();
        if (n < 4) return 1'b0;
        c = crc32_q(m_data[s], n - 4);
        return c == {m_data[s][n-1], m_data[s][n-2], m_data[s][n-3], m_data[s][n-4]};
    endfunction

    task automatic host_cmd(input logic [3:0] code, output logic [31:0] got);
        logic r0;
        erx_cs = 1'b1;
        erx_cmd = code;
        tick();
        erx_cs = 1'b0;
        r0 = erx_ready;
        tick();
        check_eq("ready_latency", {r0, erx_ready}, 2'b01);
        got = erx_data;
    endtask

    task automatic send_frame(input int odd, input int err_at, input int rst_at, input bit rel);
        int n, s;
        bit was_full, did_rst;
        n = fb.size();
        was_full = (m_cnt == SLOTS);
        did_rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            erx_dv = 1'b1;
            erx_rxd = (i == 15) ? 4'hD : 4'h5;
            tick();
        end
        for (int i = 0; i < 2*n + odd; i++) begin
            erx_rxd = (i >= 2*n) ? 4'($urandom) : (i[0] ? fb[i/2][7:4] : fb[i/2][3:0]);
            erx_err = (i == err_at);
            erx_rst_n = !(i == rst_at);
            if (i == rst_at) did_rst = 1'b1;
            tick();
        end
        erx_rst_n = 1'b1;
        erx_dv = 1'b0;
        erx_err = 1'b0;
        erx_rxd = 4'd0;
        if (rel) begin
            erx_cs = 1'b1;
            erx_cmd = 4'd3;
        end
        tick();
        erx_cs = 1'b0;
        repeat (5) tick();
        if (did_rst) begin
            m_cnt = 0;
            m_head = 0;
            m_drops = 0;
        end else begin
            if (rel && m_cnt > 0) begin
                m_head = (m_head + 1) % SLOTS;
                m_cnt--;
            end
            if (was_full) begin
                if (m_drops < 255) m_drops++;
            end else begin
                s = (m_head + m_cnt) % SLOTS;
                m_data[s] = fb;
                m_err[s] = (err_at >= 0);
                m_cnt++;
            end
        end
    endtask

    function automatic logic [31:0] model_word(input int s, input int w);
        logic [31:0] v;
        int n;
        v = '0;
        n = m_data[s].size();
        for (int b = 0; b < 4; b++)
            if (4*w + b < n) v[8*b +: 8] = m_data[s][4*w + b];
        return v;
    endfunction

    task automatic consume();
        int s, n, nw;
        logic [31:0] exp, got;
        s = m_head;
        n = m_data[s].size();
        exp = {(n > CAP), (n < 64), m_err[s], model_fcs(s), 28'(n)};
        host_cmd(4'd1, got);
        check_eq("getstat", got, exp);
        nw = ((n > CAP ? CAP : n) + 3) / 4;
        for (int w = 0; w <= nw; w++) begin
            exp = (w < nw) ? model_word(s, w) : 32'd0;
            host_cmd(4'd2, got);
            check_eq("getdata", got, exp);
        end
        host_cmd(4'd3, got);
        check_eq("release_rsp", got, 0);
        m_head = (m_head + 1) % SLOTS;
        m_cnt--;
        check_eq("frames_after_release", erx_frames, m_cnt);
    endtask

    initial begin
        logic [31:0] got;
        int n;
        repeat (3) tick();
        check_eq("rst_frames", erx_frames, 0);
        check_eq("rst_drops", erx_drops, 0);
        check_eq("rst_ready", erx_ready, 0);
        check_eq("rst_data", erx_data, 0);
        erx_rst_n = 1'b1;
        tick();

        host_cmd(4'd1, got); check_eq("empty_stat", got, 0);
        host_cmd(4'd2, got); check_eq("empty_data", got, 0);
        host_cmd(4'd3, got); check_eq("empty_rel", got, 0);
        check_eq("empty_frames", erx_frames, 0);

        erx_cs = 1'b1; erx_cmd = 4'd7; tick();
        erx_cs = 1'b0; tick(); tick();
        check_eq("bad_cmd_ready", erx_ready, 0);

        make_frame(64); send_frame(0, -1, -1, 0);
        check_eq("frames_one", erx_frames, 1);
        host_cmd(4'd1, got);
        check_eq("good64_stat", got, 32'h1000_0040);
        consume();

        make_frame(64); fb[10] = fb[10] ^ 8'h04; send_frame(0, -1, -1, 0); consume();
        make_frame(60); send_frame(0, -1, -1, 0);
        host_cmd(4'd1, got);
        check_eq("runt60_stat", got, 32'h5000_003C);
        consume();
        make_frame(37); send_frame(1, 20, -1, 0); consume();

        // a strobe while a command is in flight must not start a second one
        make_frame(20); send_frame(0, -1, -1, 0);
        host_cmd(4'd1, got);
        erx_cs = 1'b1; erx_cmd = 4'd2; tick();
        tick();
        erx_cs = 1'b0;
        check_eq("inflight_first", {erx_ready, erx_data}, {1'b1, model_word(m_head, 0)});
        tick();
        check_eq("inflight_ignored", erx_ready, 0);
        host_cmd(4'd2, got);
        check_eq("inflight_next", got, model_word(m_head, 1));
        consume();

        repeat (12) begin
            if (m_cnt == SLOTS) consume();
            n = $urandom_range(4, 140);
            make_frame(n);
            if ($urandom_range(0, 3) == 0) fb[$urandom_range(0, n-1)] ^= 8'(1 << $urandom_range(0, 7));
            send_frame($urandom_range(0, 2) == 0, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2*n-1) : -1, -1, 0);
            check_eq("rand_frames", erx_frames, m_cnt);
            check_eq("rand_drops", erx_drops, m_drops);
            if ($urandom_range(0, 1) == 1) consume();
        end

        while (m_cnt > 0) consume();
        repeat (SLOTS + 1) begin
            make_frame($urandom_range(64, 100));
            send_frame(0, -1, -1, 0);
        end
        check_eq("full_frames", erx_frames, SLOTS);
        check_eq("full_drops", erx_drops, 1);
        check_eq("full_drops_model", erx_drops, m_drops);
        consume();
        make_frame(70); send_frame(0, -1, -1, 0);
        check_eq("accept_after_release", erx_frames, SLOTS);

        consume(); consume();
        make_frame(66); send_frame(0, -1, -1, 1);
        check_eq("commit_and_release", erx_frames, 2);
        while (m_cnt > 0) consume();

        make_frame(CAP + 52); send_frame(0, -1, -1, 0);
        consume();

        make_frame(64); send_frame(0, -1, -1, 0);
        make_frame(80);
        for (int i = 20; i < 80; i++) fb[i] = 8'hD5;
        send_frame(0, -1, 40, 0);
        check_eq("midrst_frames", erx_frames, 0);
        check_eq("midrst_drops", erx_drops, 0);
        check_eq("midrst_data", erx_data, 0);
        make_frame(64); send_frame(0, -1, -1, 0);
        check_eq("after_rst_frames", erx_frames, 1);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ether_rx_ring.md
ETHER_RX_RING -- requirements
Module: ether_rx_ring

Interface
REQ-001 SHALL have parameter DATA_W, default 32, host data word width in bits (multiple of 8, >=8).
REQ-002 SHALL have parameter ADDR_W, default 9, log2 of words per frame slot.
REQ-003 SHALL have parameter SLOTS, default 4, number of frame slots (power of 2, >=2).
REQ-004 SHALL have parameter CHECK_FCS, default 1; 1 = compute CRC-32 and report FCS status, 0 = FCS bit forced 1.
REQ-005 SHALL have one clock, erx_clk, and one reset, erx_rst_n, asynchronous and active-low.
REQ-006 SHALL have ports: erx_clk in 1 MII rx clock; erx_rst_n in 1 async active-low reset; erx_rxd in 4 MII nibble; erx_dv in 1 data valid; erx_err in 1 receive error.
REQ-007 SHALL have host ports: erx_cs in 1 one-cycle command strobe; erx_cmd in 4 command; erx_ready out 1 one-cycle response pulse; erx_data out DATA_W response word.
REQ-008 SHALL have erx_frames out log2(SLOTS)+1 committed-frame count and erx_drops out 8 dropped-frame count.

Function
REQ-009 SHALL sample all inputs and update all state on rising erx_clk only.
REQ-010 SHALL run rx FSM IDLE -> PREAMBLE -> DATA -> COMMIT -> IDLE, plus DROP.
REQ-011 IDLE: erx_dv=1 -> PREAMBLE.
REQ-012 PREAMBLE: nibble 4'hD with erx_dv=1 -> DATA, clear nibble count, CRC = 32'hFFFFFFFF; erx_dv=0 -> IDLE, nothing recorded.
REQ-013 PREAMBLE with all SLOTS committed -> DROP; DROP waits for erx_dv=0, increments erx_drops (saturating at 255), -> IDLE.
REQ-014 DATA: each erx_dv=1 cycle packs erx_rxd into the current word, nibble k of a word at bits [4k+3:4k], first nibble lowest.
REQ-015 SHALL write a word to the write slot when DATA_W/4 nibbles are packed; final partial word zero-padded and written in COMMIT.
REQ-016 Length SHALL count whole bytes (nibbles/2); trailing odd nibble discarded and not stored.
REQ-017 Beyond 2^ADDR_W words, SHALL stop writing, keep counting length, set the overflow flag.
REQ-018 erx_err=1 during DATA SHALL set the error flag for that frame.
REQ-019 erx_dv=0 in DATA -> COMMIT (one cycle): stores descriptor {len, fcs_ok, err, ovf, runt (len<64)}, advances write slot modulo SLOTS, increments erx_frames, -> IDLE.
REQ-020 fcs_ok SHALL be 1 iff CRC-32 (poly 04C11DB7, reflected, nibble-serial) over all data bytes including FCS leaves residue 32'hC704DD7B.
REQ-021 Commands (erx_cmd when erx_cs=1): 1 GETSTAT, 2 GETDATA, 3 RELEASE; other codes ignored, no erx_ready.
REQ-022 Response latency SHALL be exactly 2 cycles from the erx_cs cycle to the erx_ready cycle; erx_data valid in that cycle and held until next response.
REQ-023 erx_cs while a command is in flight SHALL be ignored.
REQ-024 GETSTAT SHALL return {ovf,runt,err,fcs_ok} in [DATA_W-1:DATA_W-4], head len in the low bits, 0 elsewhere, and reset the head read pointer to 0.
REQ-025 GETDATA SHALL return the head slot word at the read pointer and increment it; past the last written word returns 0.
REQ-026 RELEASE SHALL free the head slot, advance the head modulo SLOTS, decrement erx_frames, return 0.
REQ-027 GETSTAT/GETDATA/RELEASE with erx_frames=0 SHALL return 0, change no state, still pulse erx_ready.
REQ-028 COMMIT and RELEASE in the same cycle SHALL leave erx_frames unchanged and both pointers advanced.
REQ-029 Host reads of committed slots SHALL be unaffected by concurrent reception into the write slot.

Reset
REQ-030 erx_rst_n=0 SHALL immediately set FSM to IDLE, pointers, erx_frames, erx_drops, erx_ready, erx_data to 0; frame in progress and stored frames discarded.
REQ-031 After erx_rst_n deasserts mid-frame, the block SHALL wait for erx_dv=0 then a new preamble before receiving.

Verification
REQ-032 64-byte frame with valid FCS -> erx_frames=1; GETSTAT returns fcs_ok=1, err/ovf/runt=0, len=64; 16 GETDATA return bytes little-endian.
REQ-033 Same frame with one corrupted nibble -> fcs_ok=0; 60-byte frame -> runt=1.
REQ-034 SLOTS+1 back-to-back frames, no RELEASE -> erx_frames=SLOTS, erx_drops=1; one RELEASE then new frame -> accepted.
REQ-035 Frame longer than 2^ADDR_W*DATA_W/8 bytes -> ovf=1, len = true byte count, stored words = 2^ADDR_W.
REQ-036 erx_rst_n pulsed mid-frame -> all counts 0, remaining nibbles ignored, next full frame received correctly.
REQ-037 RELEASE issued in the COMMIT cycle with erx_frames=2 -> erx_frames stays 2, head advances by one.
